// File: rtl/reservation_alu2_issue_pkg.sv
// Shared definitions for the ALU2 reservation station issue path.
// Holds the payload width, the bit position of every payload field and a
// packed struct view of the payload. LSB-first field order.
package reservation_alu2_pkg;

    localparam int RS_ALU2_PAYLOAD_W = 96;

    // Field offsets (bit position of the field's LSB) and widths
    localparam int RS_ALU2_COMMIT_TAG_OFS         = 0;
    localparam int RS_ALU2_COMMIT_TAG_W           = 6;
    localparam int RS_ALU2_DEST_REGNAME_OFS       = 6;
    localparam int RS_ALU2_DEST_REGNAME_W         = 6;
    localparam int RS_ALU2_SOURCE1_OFS            = 12;
    localparam int RS_ALU2_SOURCE1_W              = 32;
    localparam int RS_ALU2_SOURCE0_OFS            = 44;
    localparam int RS_ALU2_SOURCE0_W              = 32;
    localparam int RS_ALU2_FLAGS_REGNAME_OFS      = 76;
    localparam int RS_ALU2_FLAGS_REGNAME_W        = 4;
    localparam int RS_ALU2_FLAGS_OPT_VALID_OFS    = 80;
    localparam int RS_ALU2_ADDER_OFS              = 81;
    localparam int RS_ALU2_SHIFT_OFS              = 82;
    localparam int RS_ALU2_LOGIC_OFS              = 83;
    localparam int RS_ALU2_SYS_REG_OFS            = 84;
    localparam int RS_ALU2_AFE_OFS                = 85;
    localparam int RS_ALU2_AFE_W                  = 4;
    localparam int RS_ALU2_CMD_OFS                = 89;
    localparam int RS_ALU2_CMD_W                  = 5;
    localparam int RS_ALU2_WRITEBACK_OFS          = 94;
    localparam int RS_ALU2_DESTINATION_SYSREG_OFS = 95;

    // Packed structs list the MSB first, so the fields appear here in
    // reverse of the LSB-first layout above. The "logic" field is named
    // logic_op because logic is a keyword.
    typedef struct packed {
        logic        destination_sysreg;
        logic        writeback;
        logic [4:0]  cmd;
        logic [3:0]  afe;
        logic        sys_reg;
        logic        logic_op;
        logic        shift;
        logic        adder;
        logic        flags_opt_valid;
        logic [3:0]  flags_regname;
        logic [31:0] source0;
        logic [31:0] source1;
        logic [5:0]  dest_regname;
        logic [5:0]  commit_tag;
    } rs_alu2_payload_t;

endpackage

// File: rtl/reservation_alu2_issue_if.sv
// Bundle between the ALU2 reservation entries / ALU2 unit and the issue
// stage. The issue stage sits on the slave modport; the entries and the
// ALU side (or a testbench) sit on the master modport.
interface reservation_alu2_issue_if
    import reservation_alu2_pkg::*;
#(
    parameter int ENTRY_N = 4
);
    logic                                  iFLUSH;
    logic [ENTRY_N-1:0]                    iENTRY_REGIST;
    logic [ENTRY_N-1:0]                    iENTRY_VALID;
    logic [ENTRY_N-1:0]                    iENTRY_MATCHING;
    logic [ENTRY_N*RS_ALU2_PAYLOAD_W-1:0]  iENTRY_PAYLOAD;
    logic [ENTRY_N-1:0]                    oENTRY_EXOUT_VALID;
    logic                                  iALU_LOCK;
    logic                                  oALU_VALID;
    logic [RS_ALU2_PAYLOAD_W-1:0]          oALU_PAYLOAD;

    modport master (
        output iFLUSH, iENTRY_REGIST, iENTRY_VALID, iENTRY_MATCHING,
               iENTRY_PAYLOAD, iALU_LOCK,
        input  oENTRY_EXOUT_VALID, oALU_VALID, oALU_PAYLOAD
    );

    modport slave (
        input  iFLUSH, iENTRY_REGIST, iENTRY_VALID, iENTRY_MATCHING,
               iENTRY_PAYLOAD, iALU_LOCK,
        output oENTRY_EXOUT_VALID, oALU_VALID, oALU_PAYLOAD
    );

endinterface

// File: rtl/reservation_alu2_issue_age_matrix.sv
// Age matrix for a reservation station: tracks relative age of the entries
// from their registration strobes and returns the oldest ready entry as a
// one-hot vector. Reusable by any station with the same regist/ready view.
module reservation_age_matrix #(
    parameter int ENTRY_N = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ENTRY_N-1:0] regist,
    input  logic [ENTRY_N-1:0] rdy,
    output logic [ENTRY_N-1:0] oldest
);

    // age[i][j] = 1 means entry i is older than entry j; diagonal stays 0
    logic [ENTRY_N-1:0] age [ENTRY_N];
    logic [ENTRY_N-1:0] cand;
    logic               found;

    // A registering entry becomes youngest; among simultaneous strobes the lower index is older
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRY_N; i++) begin
                age[i] <= '0;
            end
        end else begin
            for (int i = 0; i < ENTRY_N; i++) begin
                for (int j = 0; j < ENTRY_N; j++) begin
                    if (i != j) begin
                        if (regist[i] && regist[j]) begin
                            age[i][j] <= (i < j) ? 1'b1 : 1'b0;
                        end else if (regist[i]) begin
                            age[i][j] <= 1'b0;
                        end else if (regist[j]) begin
                            age[i][j] <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    // A ready entry is a candidate when no other ready entry is older than it
    always_comb begin
        cand = '0;
        for (int i = 0; i < ENTRY_N; i++) begin
            cand[i] = rdy[i];
            for (int j = 0; j < ENTRY_N; j++) begin
                if ((j != i) && rdy[j] && age[j][i]) begin
                    cand[i] = 1'b0;
                end
            end
        end
    end

    // Equal ages (e.g. right after reset) leave several candidates; lowest index wins
    always_comb begin
        oldest = '0;
        found  = 1'b0;
        for (int i = 0; i < ENTRY_N; i++) begin
            if (cand[i] && !found) begin
                oldest[i] = 1'b1;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reservation_alu2_issue.sv
// ALU2 issue-select stage. Picks the oldest ready reservation entry, pulses
// its EXOUT_VALID (combinational grant) so it frees itself on the same edge,
// and registers its payload into a single output stage feeding ALU2.
// Honours ALU back-pressure (iALU_LOCK) and pipeline flush.
// Optional build macro RESERVATION_ALU2_ISSUE_PERF_EN adds saturating
// issue/stall performance counters.
module reservation_alu2_issue
    import reservation_alu2_pkg::*;
#(
    parameter int ENTRY_N   = 4,
    parameter int PAYLOAD_W = RS_ALU2_PAYLOAD_W
) (
    input  logic                     iCLOCK,
    input  logic                     iRESET_SYNC,
    reservation_alu2_issue_if.slave  bus
`ifdef RESERVATION_ALU2_ISSUE_PERF_EN
    ,
    output logic [31:0]              oPERF_ISSUE_COUNT,
    output logic [31:0]              oPERF_STALL_COUNT
`endif
);

    logic [ENTRY_N-1:0]   rdy;
    logic [ENTRY_N-1:0]   sel;
    logic [ENTRY_N-1:0]   grant;
    logic                 can_issue;
    logic                 any_grant;
    logic [PAYLOAD_W-1:0] grant_payload;
    logic                 alu_valid;
    rs_alu2_payload_t     alu_payload;

    assign rdy = bus.iENTRY_VALID & bus.iENTRY_MATCHING;

    reservation_age_matrix #(
        .ENTRY_N (ENTRY_N)
    ) u_age (
        .clk    (iCLOCK),
        .rst    (iRESET_SYNC),
        .regist (bus.iENTRY_REGIST),
        .rdy    (rdy),
        .oldest (sel)
    );

    // A held op blocks issue; a consumed op (lock low) frees the slot in the same cycle
    assign can_issue = !bus.iFLUSH && !(alu_valid && bus.iALU_LOCK);
    assign grant     = iRESET_SYNC ? '0 : (sel & {ENTRY_N{can_issue}});
    assign any_grant = |grant;

    // One-hot payload mux of the selected entry
    always_comb begin
        grant_payload = '0;
        for (int i = 0; i < ENTRY_N; i++) begin
            if (sel[i]) begin
                grant_payload = grant_payload | bus.iENTRY_PAYLOAD[i*PAYLOAD_W +: PAYLOAD_W];
            end
        end
    end

    // Output stage: flush beats grant, grant beats drain, lock holds the op
    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            alu_valid   <= 1'b0;
            alu_payload <= '0;
        end else if (bus.iFLUSH) begin
            alu_valid <= 1'b0;
        end else if (any_grant) begin
            alu_valid   <= 1'b1;
            alu_payload <= rs_alu2_payload_t'(grant_payload);
        end else if (!bus.iALU_LOCK) begin
            alu_valid <= 1'b0;
        end
    end

    assign bus.oENTRY_EXOUT_VALID = grant;
    assign bus.oALU_VALID         = alu_valid;
    assign bus.oALU_PAYLOAD       = alu_payload;

`ifdef RESERVATION_ALU2_ISSUE_PERF_EN
    logic [31:0] issue_count;
    logic [31:0] stall_count;

    // Saturating counters of grants and stalled cycles; only reset clears them
    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            issue_count <= '0;
            stall_count <= '0;
        end else begin
            if (any_grant && (issue_count != 32'hFFFF_FFFF)) begin
                issue_count <= issue_count + 32'd1;
            end
            if (alu_valid && bus.iALU_LOCK && (stall_count != 32'hFFFF_FFFF)) begin
                stall_count <= stall_count + 32'd1;
            end
        end
    end

    assign oPERF_ISSUE_COUNT = issue_count;
    assign oPERF_STALL_COUNT = stall_count;
`endif

endmodule

// File: tb/tb_reservation_alu2_issue.sv
// Directed testbench for reservation_alu2_issue (ENTRY_N = 4).
// Inputs change 1 time unit after a rising edge; the combinational grant is
// checked 1 unit later, registered outputs right after the following edge.
module tb_reservation_alu2_issue;
    import reservation_alu2_pkg::*;

    localparam int N = 4;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    reservation_alu2_issue_if #(.ENTRY_N(N)) bus ();

`ifdef RESERVATION_ALU2_ISSUE_PERF_EN
    logic [31:0] perf_issue;
    logic [31:0] perf_stall;
`endif

    reservation_alu2_issue #(
        .ENTRY_N (N)
    ) dut (
        .iCLOCK      (clk),
        .iRESET_SYNC (rst),
        .bus         (bus)
`ifdef RESERVATION_ALU2_ISSUE_PERF_EN
        ,
        .oPERF_ISSUE_COUNT (perf_issue),
        .oPERF_STALL_COUNT (perf_stall)
`endif
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run always ends
    initial begin
        #20000;
        $display("[TB] FAIL timeout reached before end of sequence");
        $fatal(1, "[TB] timeout");
    end

    function automatic logic [95:0] make_payload(input logic [5:0] tag,
                                                 input logic [5:0] dest,
                                                 input logic [4:0] cmd);
        rs_alu2_payload_t p;
        p              = '0;
        p.commit_tag   = tag;
        p.dest_regname = dest;
        p.cmd          = cmd;
        p.source0      = 32'hA5A5_0000 | {26'h0, tag};
        p.source1      = 32'h1234_0000 | {26'h0, dest};
        p.adder        = tag[0];
        p.afe          = tag[3:0];
        return p;
    endfunction

    task automatic check_output(input string tag, input logic [95:0] observed,
                                input logic [95:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [N-1:0] valid, input logic [N-1:0] matching,
                                  input logic flush, input logic lock);
        bus.iENTRY_VALID    = valid;
        bus.iENTRY_MATCHING = matching;
        bus.iFLUSH          = flush;
        bus.iALU_LOCK       = lock;
        #1;
    endtask

    task automatic regist_pulse(input logic [N-1:0] r);
        bus.iENTRY_REGIST = r;
        tick();
        bus.iENTRY_REGIST = '0;
    endtask

    task automatic set_payload(input int idx, input logic [95:0] p);
        bus.iENTRY_PAYLOAD[idx*96 +: 96] = p;
    endtask

    logic [95:0]      pl_a, pl_b, pl_c;
    rs_alu2_payload_t view;

    initial begin
        rst                = 1'b1;
        bus.iFLUSH         = 1'b0;
        bus.iENTRY_REGIST  = '0;
        bus.iENTRY_VALID   = '0;
        bus.iENTRY_MATCHING= '0;
        bus.iENTRY_PAYLOAD = '0;
        bus.iALU_LOCK      = 1'b0;
        set_payload(0, make_payload(6'h3F, 6'h3F, 5'h1F));

        // Reset: a ready entry must not be granted while reset is high
        tick();
        apply_stimulus(4'b0001, 4'b0001, 1'b0, 1'b0);
        check_output("reset_grant", bus.oENTRY_EXOUT_VALID, 4'b0000);
        tick();
        check_output("reset_valid", bus.oALU_VALID, 1'b0);
        check_output("reset_payload", bus.oALU_PAYLOAD, 96'h0);
        rst = 1'b0;
        apply_stimulus(4'b0000, 4'b0000, 1'b0, 1'b0);

        // Single ready entry 2
        pl_a = make_payload(6'h02, 6'h11, 5'h03);
        set_payload(2, pl_a);
        apply_stimulus(4'b0100, 4'b0100, 1'b0, 1'b0);
        check_output("t1_grant", bus.oENTRY_EXOUT_VALID, 4'b0100);
        tick();
        check_output("t1_valid", bus.oALU_VALID, 1'b1);
        view = bus.oALU_PAYLOAD;
        check_output("t1_cmd", view.cmd, 5'h03);
        check_output("t1_dest", view.dest_regname, 6'h11);
        check_output("t1_payload", bus.oALU_PAYLOAD, pl_a);
        apply_stimulus(4'b0000, 4'b0000, 1'b0, 1'b0);
        check_output("t1_idle_grant", bus.oENTRY_EXOUT_VALID, 4'b0000);
        tick();
        check_output("t1_drop_valid", bus.oALU_VALID, 1'b0);

        // Valid but operands not ready: no grant
        apply_stimulus(4'b0001, 4'b0000, 1'b0, 1'b0);
        check_output("nomatch_grant", bus.oENTRY_EXOUT_VALID, 4'b0000);
        apply_stimulus(4'b0000, 4'b0000, 1'b0, 1'b0);

        // Registration order 3,0,1 decides issue order
        regist_pulse(4'b1000);
        regist_pulse(4'b0001);
        regist_pulse(4'b0010);
        pl_a = make_payload(6'h30, 6'h01, 5'h04);
        pl_b = make_payload(6'h31, 6'h02, 5'h05);
        pl_c = make_payload(6'h33, 6'h03, 5'h06);
        set_payload(0, pl_a);
        set_payload(1, pl_b);
        set_payload(3, pl_c);
        apply_stimulus(4'b1011, 4'b1011, 1'b0, 1'b0);
        check_output("t2_grant3", bus.oENTRY_EXOUT_VALID, 4'b1000);
        tick();
        check_output("t2_payload3", bus.oALU_PAYLOAD, pl_c);
        apply_stimulus(4'b0011, 4'b0011, 1'b0, 1'b0);
        check_output("t2_grant0", bus.oENTRY_EXOUT_VALID, 4'b0001);
        tick();
        check_output("t2_payload0", bus.oALU_PAYLOAD, pl_a);
        check_output("t2_valid0", bus.oALU_VALID, 1'b1);
        apply_stimulus(4'b0010, 4'b0010, 1'b0, 1'b0);
        check_output("t2_grant1", bus.oENTRY_EXOUT_VALID, 4'b0010);
        tick();
        check_output("t2_payload1", bus.oALU_PAYLOAD, pl_b);
        apply_stimulus(4'b0000, 4'b0000, 1'b0, 1'b0);
        tick();
        check_output("t2_end_valid", bus.oALU_VALID, 1'b0);

        // Back-pressure: held op stays stable, entry 1 waits, then issues on release
        pl_a = make_payload(6'h20, 6'h07, 5'h08);
        pl_b = make_payload(6'h21, 6'h08, 5'h09);
        set_payload(0, pl_a);
        set_payload(1, pl_b);
        apply_stimulus(4'b0001, 4'b0001, 1'b0, 1'b0);
        check_output("t3_grant0", bus.oENTRY_EXOUT_VALID, 4'b0001);
        tick();
        check_output("t3_payload0", bus.oALU_PAYLOAD, pl_a);
        apply_stimulus(4'b0010, 4'b0010, 1'b0, 1'b1);
        check_output("t3_lock_grant", bus.oENTRY_EXOUT_VALID, 4'b0000);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_output("t3_hold_valid", bus.oALU_VALID, 1'b1);
            check_output("t3_hold_payload", bus.oALU_PAYLOAD, pl_a);
            check_output("t3_hold_grant", bus.oENTRY_EXOUT_VALID, 4'b0000);
        end
        apply_stimulus(4'b0010, 4'b0010, 1'b0, 1'b0);
        check_output("t3_release_grant", bus.oENTRY_EXOUT_VALID, 4'b0010);
        tick();
        check_output("t3_release_valid", bus.oALU_VALID, 1'b1);
        check_output("t3_release_payload", bus.oALU_PAYLOAD, pl_b);
        apply_stimulus(4'b0000, 4'b0000, 1'b0, 1'b0);
        tick();
`ifdef RESERVATION_ALU2_ISSUE_PERF_EN
        check_output("perf_issue_mid", perf_issue, 32'd6);
        check_output("perf_stall_mid", perf_stall, 32'd3);
`endif

        // Flush while an op is held under lock
        pl_a = make_payload(6'h22, 6'h0A, 5'h0B);
        pl_b = make_payload(6'h10, 6'h0C, 5'h0D);
        set_payload(2, pl_a);
        apply_stimulus(4'b0100, 4'b0100, 1'b0, 1'b0);
        check_output("t4_grant2", bus.oENTRY_EXOUT_VALID, 4'b0100);
        tick();
        apply_stimulus(4'b0000, 4'b0000, 1'b0, 1'b1);
        tick();
        check_output("t4_held_payload", bus.oALU_PAYLOAD, pl_a);
        set_payload(0, pl_b);
        apply_stimulus(4'b0001, 4'b0001, 1'b1, 1'b1);
        check_output("t4_flush_grant", bus.oENTRY_EXOUT_VALID, 4'b0000);
        tick();
        check_output("t4_flush_valid", bus.oALU_VALID, 1'b0);
        apply_stimulus(4'b0001, 4'b0001, 1'b0, 1'b0);
        check_output("t4_after_grant", bus.oENTRY_EXOUT_VALID, 4'b0001);
        tick();
        check_output("t4_after_payload", bus.oALU_PAYLOAD, pl_b);
        apply_stimulus(4'b0000, 4'b0000, 1'b0, 1'b0);
        tick();

        // Same-cycle registration of 1 and 2: lower index is older
        regist_pulse(4'b0110);
        pl_a = make_payload(6'h01, 6'h15, 5'h11);
        pl_b = make_payload(6'h02, 6'h16, 5'h12);
        set_payload(1, pl_a);
        set_payload(2, pl_b);
        apply_stimulus(4'b0110, 4'b0110, 1'b0, 1'b0);
        check_output("t5_grant1", bus.oENTRY_EXOUT_VALID, 4'b0010);
        tick();
        check_output("t5_payload1", bus.oALU_PAYLOAD, pl_a);
        apply_stimulus(4'b0100, 4'b0100, 1'b0, 1'b0);
        check_output("t5_grant2", bus.oENTRY_EXOUT_VALID, 4'b0100);
        tick();
        check_output("t5_payload2", bus.oALU_PAYLOAD, pl_b);
        apply_stimulus(4'b0000, 4'b0000, 1'b0, 1'b0);
        tick();
        check_output("t5_end_valid", bus.oALU_VALID, 1'b0);
`ifdef RESERVATION_ALU2_ISSUE_PERF_EN
        check_output("perf_issue_end", perf_issue, 32'd10);
        check_output("perf_stall_end", perf_stall, 32'd5);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reservation_alu2_issue.md
Name: reservation_alu2_issue

Overview:
Issue-select stage directly downstream of the ALU2 reservation entries.
- Each cycle, picks the oldest valid entry whose operands are both ready (entry MATCHING=1).
- Pulses that entry's EXOUT_VALID so the entry frees itself at the same clock edge.
- Registers the entry's payload into a single-stage output register that feeds the ALU2 execution unit.
- Honours back-pressure from ALU2 and the pipeline flush.

Parameters:
- ENTRY_N, 4, number of reservation entries served (2..8).
- PAYLOAD_W, 96, packed payload width per entry (fixed by package layout; not to be overridden).

Ports:
- iCLOCK  in  1  clock; all state changes on rising edge.
- iRESET_SYNC  in  1  synchronous, active-high reset.
- iFLUSH  in  1  pipeline flush (same source as entry REMOVE_VALID).
- iENTRY_REGIST  in  ENTRY_N  per-entry registration strobe (entry accepted a new op this cycle).
- iENTRY_VALID  in  ENTRY_N  per-entry valid (entry state).
- iENTRY_MATCHING  in  ENTRY_N  per-entry both-sources-ready.
- iENTRY_PAYLOAD  in  ENTRY_N*PAYLOAD_W  packed per-entry payload; entry i at bits [i*PAYLOAD_W +: PAYLOAD_W].
- oENTRY_EXOUT_VALID  out  ENTRY_N  one-hot grant, combinational; drives entry EXOUT_VALID.
- iALU_LOCK  in  1  ALU2 cannot accept; output must hold.
- oALU_VALID  out  1  issued op valid.
- oALU_PAYLOAD  out  PAYLOAD_W  issued op payload (registered).

Behaviour:
- Reset: when iRESET_SYNC is high at a rising edge:
  - oALU_VALID=0, oALU_PAYLOAD=0, age matrix all 0.
  - oENTRY_EXOUT_VALID is forced 0 while iRESET_SYNC is high.
- Age matrix: age[i][j]=1 means entry i is older than entry j (off-diagonal only).
  - On iENTRY_REGIST[k]: age[k][*]<=0 and age[*][k]<=1, so k becomes youngest.
  - Multiple strobes in one cycle: lower index is treated as older among them.
- Ready set: rdy[i] = iENTRY_VALID[i] & iENTRY_MATCHING[i].
- Select: sel[i] = rdy[i] & no j with rdy[j] & age[j][i].
  - If ages are equal (post-reset), the lowest index wins, so the grant is always one-hot.
- Issue enable: can_issue = !iFLUSH & !(oALU_VALID & iALU_LOCK).
- Grant: oENTRY_EXOUT_VALID = sel & {ENTRY_N{can_issue}}. Pure combinational, same cycle as select.
- Output register, priority order:
  - iFLUSH → valid<=0.
  - else grant → valid<=1, payload<=granted payload.
  - else if !iALU_LOCK → valid<=0.
  - else hold.
- Latency: entry MATCHING high in cycle N → oALU_VALID in N+1. The entry is invalid in N+1.
- Back-pressure: while oALU_VALID & iALU_LOCK, payload is stable and no grant is issued. When lock releases, the held op is consumed and a new grant is allowed in that same cycle (back-to-back throughput of 1/cycle).
- Flush mid-stall: discards the held op; no grant in the flush cycle.
- No ready entries: grant=0; oALU_VALID drops unless held by lock.
- Payload layout (LSB first):
  - commit_tag[5:0], dest_regname[5:0], source1[31:0], source0[31:0]
  - flags_regname[3:0], flags_opt_valid, adder, shift, logic, sys_reg
  - afe[3:0], cmd[4:0], writeback, destination_sysreg
  - Total 96 bits.

Optional Feature:
- RESERVATION_ALU2_ISSUE_PERF_EN
- Defined: adds oPERF_ISSUE_COUNT[31:0] and oPERF_STALL_COUNT[31:0].
  - Issue count increments per grant.
  - Stall count increments per cycle with oALU_VALID & iALU_LOCK.
  - Both counters saturate at 32'hFFFFFFFF.
  - Cleared by reset only; flush does not clear them.
- Undefined: these ports and counters do not exist.

Decomposition:
- Package reservation_alu2_pkg holds:
  - RS_ALU2_PAYLOAD_W=96.
  - Field offset/width constants for every payload field.
  - A packed struct typedef of the payload.
- One sub-module: reservation_age_matrix. It owns the age bits and regist update and takes the ready vector. It outputs the one-hot oldest-ready vector, and is reusable by the other reservation stations.

Test Plan:
- Reset, then entry 2 rdy with payload cmd=5'h03, dest=6'h11 → grant=4'b0100 that cycle; next cycle oALU_VALID=1, cmd=03, dest=11.
- Regist order 3,0,1; all three become rdy together → grants 3, then 0, then 1 on consecutive cycles, with entries deasserting valid after each grant.
- iALU_LOCK=1 for 3 cycles with op held and entry 1 rdy → no grant, payload constant. Lock drops → entry 1 granted the same cycle, with its op valid the next cycle.
- iFLUSH during lock with held op → oALU_VALID=0 next cycle, grant=0 in the flush cycle.
- Same-cycle regist of entries 1 and 2, both later rdy → entry 1 granted first.
- PERF_EN: 5 grants plus 3 lock cycles → ISSUE=5, STALL=3. Preloaded ISSUE=32'hFFFFFFFF plus one grant → stays FFFFFFFF.
